// File: rtl/ct_l2c_prf_arb.sv
// ct_l2c_prf_arb: two-source round-robin prefetch arbiter toward the CIU with
// same-line merge, an output holding register and a programmable post-accept gap.

module gated_clk_cell (
   input  logic clk_in,
   input  logic local_en,
   input  logic module_en,
   input  logic pad_yy_icg_scan_en,
   output logic clk_out
);
   logic r_en_lat;

   // NOTE: the enable is latched while the clock is low, so clk_out cannot glitch.
   always_latch begin
      if (!clk_in) r_en_lat <= local_en | module_en | pad_yy_icg_scan_en;
   end

   assign clk_out = clk_in & r_en_lat;
endmodule

module ct_l2c_prf_arb (
   input  logic        forever_cpuclk,
   input  logic        cpurst_b,
   input  logic        l2c_icg_en,
   input  logic        pad_yy_icg_scan_en,
   input  logic        pf0_arb_vld,
   input  logic [33:0] pf0_arb_addr,
   input  logic [2:0]  pf0_arb_prot,
   output logic        arb_pf0_ready,
   input  logic        pf1_arb_vld,
   input  logic [33:0] pf1_arb_addr,
   input  logic [2:0]  pf1_arb_prot,
   output logic        arb_pf1_ready,
   input  logic        prf_arb_flush,
   input  logic [1:0]  ciu_l2c_prf_gap,
   input  logic        ciu_l2c_prf_ready,
   output logic        l2c_ciu_prf_vld,
   output logic [33:0] l2c_ciu_prf_addr,
   output logic [2:0]  l2c_ciu_prf_prot,
   output logic        prf_arb_idle
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      GAP   = 2'd2
   } state_e;

   state_e      r_state;
   state_e      w_state_nxt;
   logic [1:0]  r_cnt;
   logic [1:0]  w_cnt_nxt;
   logic        r_rr_ptr;
   logic [33:0] r_addr;
   logic [2:0]  r_prot;

   logic        w_xfer;
   logic        w_slot_free;
   logic        w_load;
   logic        w_both;
   logic        w_merge;
   logic        w_win1;
   logic        w_local_en;
   logic        w_gclk;

   assign w_xfer      = l2c_ciu_prf_vld & ciu_l2c_prf_ready;
   assign w_slot_free = (r_state == IDLE)
                      | ((r_state == ISSUE) & w_xfer & (ciu_l2c_prf_gap == 2'd0))
                      | ((r_state == GAP) & (r_cnt == 2'd1));
   assign w_load      = ~prf_arb_flush & (pf0_arb_vld | pf1_arb_vld) & w_slot_free;

   // Under contention rr_ptr names the winner; a merge consumes both requests.
   assign w_both        = pf0_arb_vld & pf1_arb_vld;
   assign w_merge       = w_both & (pf0_arb_addr == pf1_arb_addr);
   assign w_win1        = w_both ? r_rr_ptr : pf1_arb_vld;
   assign arb_pf0_ready = w_load & (~w_win1 | w_merge);
   assign arb_pf1_ready = w_load & (w_win1 | w_merge);

   assign l2c_ciu_prf_vld  = (r_state == ISSUE);
   assign prf_arb_idle     = (r_state == IDLE);
   assign l2c_ciu_prf_addr = r_addr;
   assign l2c_ciu_prf_prot = r_prot;

   // Every state change coincides with one of these terms, so gating is invisible.
   assign w_local_en = w_load | w_xfer | prf_arb_flush | (r_state == GAP);

   gated_clk_cell x_gated_clk_cell (
      .clk_in             (forever_cpuclk),
      .local_en           (w_local_en),
      .module_en          (l2c_icg_en),
      .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
      .clk_out            (w_gclk)
   );

   // NOTE: every always_comb output gets a default first, so no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (w_load) w_state_nxt = ISSUE;
         end
         ISSUE: begin
            if (prf_arb_flush) begin
               w_state_nxt = IDLE;
            end else if (w_xfer) begin
               if (ciu_l2c_prf_gap == 2'd0) begin
                  w_state_nxt = w_load ? ISSUE : IDLE;
               end else begin
                  w_cnt_nxt   = ciu_l2c_prf_gap;
                  w_state_nxt = GAP;
               end
            end
         end
         GAP: begin
            if (prf_arb_flush) begin
               w_cnt_nxt   = 2'd0;
               w_state_nxt = IDLE;
            end else if (r_cnt == 2'd1) begin
               w_cnt_nxt   = 2'd0;
               w_state_nxt = w_load ? ISSUE : IDLE;
            end else begin
               w_cnt_nxt = r_cnt - 2'd1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge w_gclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         r_state  <= IDLE;
         r_cnt    <= 2'd0;
         r_rr_ptr <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_load) r_rr_ptr <= ~w_win1;
      end
   end

   // The output register is not cleared on flush; vld alone marks it empty.
   always_ff @(posedge w_gclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         r_addr <= 34'd0;
         r_prot <= 3'd0;
      end else if (w_load) begin
         r_addr <= w_win1 ? pf1_arb_addr : pf0_arb_addr;
         r_prot <= w_win1 ? pf1_arb_prot : pf0_arb_prot;
      end
   end
endmodule

// File: tb/tb_ct_l2c_prf_arb.sv
// Self-checking bench for ct_l2c_prf_arb: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.

module tb_ct_l2c_prf_arb;
   logic        clk;
   logic        rst_b;
   logic        icg_en;
   logic        scan_en;
   logic        pf0_vld, pf1_vld;
   logic [33:0] pf0_addr, pf1_addr;
   logic [2:0]  pf0_prot, pf1_prot;
   logic        r0, r1;
   logic        flush;
   logic [1:0]  gap;
   logic        ciu_rdy;
   logic        vld;
   logic [33:0] addr;
   logic [2:0]  prot;
   logic        idle;

   int n_tests = 0;
   int n_fail  = 0;

   ct_l2c_prf_arb dut (
      .forever_cpuclk     (clk),
      .cpurst_b           (rst_b),
      .l2c_icg_en         (icg_en),
      .pad_yy_icg_scan_en (scan_en),
      .pf0_arb_vld        (pf0_vld),
      .pf0_arb_addr       (pf0_addr),
      .pf0_arb_prot       (pf0_prot),
      .arb_pf0_ready      (r0),
      .pf1_arb_vld        (pf1_vld),
      .pf1_arb_addr       (pf1_addr),
      .pf1_arb_prot       (pf1_prot),
      .arb_pf1_ready      (r1),
      .prf_arb_flush      (flush),
      .ciu_l2c_prf_gap    (gap),
      .ciu_l2c_prf_ready  (ciu_rdy),
      .l2c_ciu_prf_vld    (vld),
      .l2c_ciu_prf_addr   (addr),
      .l2c_ciu_prf_prot   (prot),
      .prf_arb_idle       (idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Behavioural model: an output slot, a count of idle cycles still owed, and
   // whose turn it is under contention.
   bit          m_vld;
   logic [33:0] m_addr;
   logic [2:0]  m_prot;
   int          m_wait;
   bit          m_rr;

   always @(negedge clk) begin : compare
      bit xfer, take, merge, win1;
      if (!rst_b) begin
         m_vld  = 1'b0;
         m_addr = '0;
         m_prot = '0;
         m_wait = 0;
         m_rr   = 1'b0;
         check("rst_vld", vld, 0);
         check("rst_idle", idle, 1);
         check("rst_addr", addr, 0);
         check("rst_prot", prot, 0);
      end else begin
         check("m_vld", vld, m_vld);
         check("m_addr", addr, m_addr);
         check("m_prot", prot, m_prot);
         check("m_idle", idle, (!m_vld && m_wait == 0));
         xfer  = m_vld && ciu_rdy;
         take  = !flush && (pf0_vld || pf1_vld) &&
                 ((!m_vld && m_wait == 0) || (xfer && gap == 0) || m_wait == 1);
         merge = pf0_vld && pf1_vld && (pf0_addr == pf1_addr);
         win1  = (pf0_vld && pf1_vld) ? m_rr : pf1_vld;
         check("m_r0", r0, take && (!win1 || merge));
         check("m_r1", r1, take && (win1 || merge));
         if (flush) begin
            m_vld  = 1'b0;
            m_wait = 0;
         end else if (take) begin
            m_vld  = 1'b1;
            m_wait = 0;
            m_addr = win1 ? pf1_addr : pf0_addr;
            m_prot = win1 ? pf1_prot : pf0_prot;
            m_rr   = !win1;
         end else if (xfer) begin
            m_vld  = 1'b0;
            m_wait = gap;
         end else if (m_wait > 0) begin
            m_wait = m_wait - 1;
         end
      end
   end

   function automatic logic [33:0] pick_addr();
      if ($urandom_range(0, 1) == 0) return 34'(32'h40 * $urandom_range(0, 3));
      return {2'($urandom), 32'($urandom)};
   endfunction

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not complete, actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin : main
      bit g0, g1;
      rst_b = 1'b1; icg_en = 1'b1; scan_en = 1'b0;
      pf0_vld = 0; pf0_addr = '0; pf0_prot = '0;
      pf1_vld = 0; pf1_addr = '0; pf1_prot = '0;
      flush = 0; gap = 2'd0; ciu_rdy = 0;
      #1 rst_b = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_b = 1'b1; icg_en = 1'b0;
      @(negedge clk);
      check("reset_vld", vld, 0);
      check("reset_addr", addr, 0);
      check("reset_prot", prot, 0);
      check("reset_r0", r0, 0);
      check("reset_r1", r1, 0);
      check("reset_idle", idle, 1);

      // Single request, held two cycles, then accepted.
      tick(); pf0_vld = 1; pf0_addr = 34'h100; pf0_prot = 3'b011;
      @(negedge clk); check("a_r0", r0, 1); check("a_r1", r1, 0); check("a_vld0", vld, 0);
      tick(); pf0_vld = 0;
      @(negedge clk); check("a_vld", vld, 1); check("a_addr", addr, 34'h100); check("a_prot", prot, 3'b011);
      tick();
      @(negedge clk); check("a_hold", addr, 34'h100);
      tick(); ciu_rdy = 1;
      @(negedge clk); check("a_vld_x", vld, 1);
      tick(); ciu_rdy = 0;
      @(negedge clk); check("a_done_vld", vld, 0); check("a_done_idle", idle, 1);

      // Merge with rr_ptr = 1, then contention resumes at source 0.
      tick(); pf0_vld = 1; pf0_addr = 34'h2A0; pf0_prot = 3'b000;
              pf1_vld = 1; pf1_addr = 34'h2A0; pf1_prot = 3'b111;
      @(negedge clk); check("m_both_r0", r0, 1); check("m_both_r1", r1, 1);
      tick(); pf0_vld = 0; pf1_vld = 0;
      @(negedge clk); check("m_addr_lit", addr, 34'h2A0); check("m_prot_lit", prot, 3'b111);
      tick(); pf0_vld = 1; pf0_addr = 34'h400; pf0_prot = 3'b010;
              pf1_vld = 1; pf1_addr = 34'h500; pf1_prot = 3'b101; ciu_rdy = 1;
      @(negedge clk); check("c_r0", r0, 1); check("c_r1", r1, 0);
      tick(); pf0_vld = 0;
      @(negedge clk); check("c_addr0", addr, 34'h400); check("c_r1b", r1, 1);
      tick(); pf1_vld = 0;
      @(negedge clk); check("c_addr1", addr, 34'h500); check("c_prot1", prot, 3'b101);
      tick(); ciu_rdy = 0;
      @(negedge clk); check("c_idle", idle, 1);

      // gap = 2: vld low two cycles, reload in the last gap cycle.
      tick(); gap = 2'd2; pf0_vld = 1; pf0_addr = 34'h600; pf0_prot = 3'b001;
      @(negedge clk); check("g_r0_first", r0, 1);
      tick(); pf0_addr = 34'h610; ciu_rdy = 1;
      @(negedge clk); check("g_vld_T", vld, 1); check("g_r0_T", r0, 0);
      tick(); ciu_rdy = 0;
      @(negedge clk); check("g_vld_T1", vld, 0); check("g_r0_T1", r0, 0); check("g_idle_T1", idle, 0);
      tick();
      @(negedge clk); check("g_vld_T2", vld, 0); check("g_r0_T2", r0, 1);
      tick(); pf0_vld = 0;
      @(negedge clk); check("g_vld_T3", vld, 1); check("g_addr_T3", addr, 34'h610);
      tick(); gap = 2'd0; ciu_rdy = 1;
      @(negedge clk); check("g_drain", vld, 1);
      tick(); ciu_rdy = 0;
      @(negedge clk); check("g_drain_idle", idle, 1);

      // Held five cycles, then flush with CIU ready: no gap is started.
      tick(); pf0_vld = 1; pf0_addr = 34'h700; pf0_prot = 3'b110;
      @(negedge clk); check("h_r0", r0, 1);
      tick(); pf0_vld = 0; pf1_vld = 1; pf1_addr = 34'h710; pf1_prot = 3'b011;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("h_vld", vld, 1); check("h_addr", addr, 34'h700); check("h_prot", prot, 3'b110);
         check("h_r0_hold", r0, 0); check("h_r1_hold", r1, 0);
         tick();
      end
      flush = 1; ciu_rdy = 1; gap = 2'd3;
      @(negedge clk); check("f_r1", r1, 0); check("f_vld", vld, 1);
      tick(); flush = 0; ciu_rdy = 0;
      @(negedge clk); check("f_vld_after", vld, 0); check("f_r1_after", r1, 1);
      tick(); pf1_vld = 0;
      @(negedge clk); check("f_addr", addr, 34'h710); check("f_prot", prot, 3'b011);

      // Flush during GAP with cnt = 2; the pending request loads next cycle.
      tick(); ciu_rdy = 1;
      @(negedge clk); check("e_vld_T", vld, 1);
      tick(); ciu_rdy = 0;
      @(negedge clk); check("e_vld_T1", vld, 0); check("e_idle_T1", idle, 0);
      tick(); flush = 1; pf0_vld = 1; pf0_addr = 34'h800; pf0_prot = 3'b100;
      @(negedge clk); check("e_r0_flush", r0, 0); check("e_vld_T2", vld, 0);
      tick(); flush = 0;
      @(negedge clk); check("e_idle_T3", idle, 1); check("e_r0_T3", r0, 1);
      tick(); pf0_vld = 0; gap = 2'd0;
      @(negedge clk); check("e_addr", addr, 34'h800); check("e_prot", prot, 3'b100);

      // Reset mid-operation, then continuous contention alternates 0,1,0,1.
      tick(); rst_b = 0;
      @(negedge clk); check("r_vld", vld, 0); check("r_idle", idle, 1);
      tick(); rst_b = 1;
      pf0_vld = 1; pf0_addr = 34'h1000; pf0_prot = 3'b000;
      pf1_vld = 1; pf1_addr = 34'h2000; pf1_prot = 3'b001; ciu_rdy = 1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("alt_r0", r0, (i % 2 == 0));
         check("alt_r1", r1, (i % 2 == 1));
         tick();
         if (i % 2 == 0) pf0_addr = pf0_addr + 34'd1;
         else            pf1_addr = pf1_addr + 34'd1;
      end
      pf0_vld = 0; pf1_vld = 0;
      tick(); ciu_rdy = 0;

      // Randomized traffic; sources honour the hold-until-ready protocol.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         g0 = r0;
         g1 = r1;
         tick();
         rst_b = (c != 1500);
         if (!pf0_vld || g0) begin
            pf0_vld  = ($urandom_range(0, 99) < 60);
            pf0_addr = pick_addr();
            pf0_prot = 3'($urandom);
         end
         if (!pf1_vld || g1) begin
            pf1_vld  = ($urandom_range(0, 99) < 60);
            pf1_addr = ($urandom_range(0, 2) == 0) ? pf0_addr : pick_addr();
            pf1_prot = 3'($urandom);
         end
         ciu_rdy = ($urandom_range(0, 99) < 60);
         flush   = ($urandom_range(0, 99) < 4);
         gap     = 2'($urandom_range(0, 3));
         icg_en  = ($urandom_range(0, 3) == 0);
         scan_en = ($urandom_range(0, 15) == 0);
      end

      tick();
      rst_b = 1; pf0_vld = 0; pf1_vld = 0; flush = 0; ciu_rdy = 1; gap = 2'd0;
      repeat (6) tick();
      @(negedge clk);
      check("end_idle", idle, 1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
